// File: rtl/memmux_scanout.sv
// memmux_scanout
// Video-side reader for the double-buffered memory mux. Walks the video
// port one word at a time through a frame, presents each word on a
// valid/ready pixel stream, and owns the buffer select. The select only
// flips in the one-cycle frame-end state, and only when the frame writer
// is requesting a swap, so a frame is never read from two buffers.
//
// Per-word cadence: ISSUE (address out) -> LOAD (data returns, captured at
// the closing edge) -> SHOW (held until the consumer takes it).

module memmux_scanout #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  switch,
    output logic [ADDR_WIDTH-1:0] mADDR_V,
    input  logic [DATA_WIDTH-1:0] mDATA_V,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  frame_done,
    output logic [7:0]            repeat_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHOW  = 3'd3,
        ST_FEND  = 3'd4
    } state_t;

    // Last word index of a frame; the pointer stops here and never wraps,
    // which also covers FRAME_LEN == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

    // Saturating increment for the rescan counter: sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = 8'hFF;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    state_t                  state_q,      state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
    logic [ADDR_WIDTH-1:0]   maddr_q,      maddr_d;
    logic [DATA_WIDTH-1:0]   pix_data_q,   pix_data_d;
    logic                    pix_valid_q,  pix_valid_d;
    logic                    switch_q,     switch_d;
    logic                    swap_ack_q,   swap_ack_d;
    logic                    frame_done_q, frame_done_d;
    logic [7:0]              repeat_q,     repeat_d;

    // Next-state and next-output decode for the scanout sequencer.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = pix_valid_q;
        switch_d     = switch_q;
        swap_ack_d   = 1'b0;
        frame_done_d = 1'b0;
        repeat_d     = repeat_q;

        case (state_q)
            ST_IDLE: begin
                pix_valid_d = 1'b0;
                addr_d      = ZERO_ADDR;
                if (enable) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                // Address is already on the port; memory answers next cycle.
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                pix_data_d  = mDATA_V;
                pix_valid_d = 1'b1;
                state_d     = ST_SHOW;
            end

            ST_SHOW: begin
                if (pix_valid_q && pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_FEND;
                    end else begin
                        addr_d  = addr_q + ONE_ADDR;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    // Backpressure: hold word, address and valid.
                    state_d = ST_SHOW;
                end
            end

            ST_FEND: begin
                frame_done_d = 1'b1;
                addr_d       = ZERO_ADDR;
                // Only place the buffer select may change: no word in flight.
                if (swap_req) begin
                    switch_d   = ~switch_q;
                    swap_ack_d = 1'b1;
                    repeat_d   = 8'd0;
                end else begin
                    repeat_d   = sat_inc8(repeat_q);
                end
                if (enable) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                addr_d      = ZERO_ADDR;
                pix_valid_d = 1'b0;
            end
        endcase
    end

    // Video address tracks the word pointer, parked at zero while idle.
    always_comb begin
        maddr_d = ZERO_ADDR;
        if (state_d == ST_IDLE) begin
            maddr_d = ZERO_ADDR;
        end else begin
            maddr_d = addr_d;
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= ZERO_ADDR;
            maddr_q      <= ZERO_ADDR;
            pix_data_q   <= {DATA_WIDTH{1'b0}};
            pix_valid_q  <= 1'b0;
            switch_q     <= 1'b0;
            swap_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            repeat_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            maddr_q      <= maddr_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            switch_q     <= switch_d;
            swap_ack_q   <= swap_ack_d;
            frame_done_q <= frame_done_d;
            repeat_q     <= repeat_d;
        end
    end

    assign mADDR_V    = maddr_q;
    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign switch     = switch_q;
    assign swap_ack   = swap_ack_q;
    assign frame_done = frame_done_q;
    assign repeat_cnt = repeat_q;

endmodule
